// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer between the PC register and the L1 I-cache.
// Issues fetches, holds the request across misses, freezes the PC while a
// miss or a buffered word is outstanding, and replays redirects that arrive
// mid-miss through redirect_o / redirect_pc_o.
module if_fetch_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic             pc_ce_i,
  input  logic             id_stall_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  input  logic             flush_i,
  input  logic [31:0]      new_pc_i,
  output logic             ic_req_o,
  output logic [31:0]      ic_addr_o,
  input  logic             ic_ack_i,
  input  logic [31:0]      ic_rdata_i,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  output logic             stall_req_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      inst_q, inst_d;
  logic             valid_q, valid_d;
  logic             redir_q, redir_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             pend_q, pend_d;
  logic             pend_flush_q, pend_flush_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, datapath next values and combinational cache/PC controls
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    redir_d      = 1'b0;
    rpc_d        = rpc_q;
    pend_d       = pend_q;
    pend_flush_d = pend_flush_q;
    pend_pc_d    = pend_pc_q;
    cnt_d        = cnt_q;
    ic_req_o     = 1'b0;
    ic_addr_o    = addr_q;
    stall_req_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pc_ce_i) state_d = FETCH;
      end

      FETCH: begin
        ic_req_o    = pc_ce_i & ~id_stall_i;
        ic_addr_o   = pc_i;
        stall_req_o = ic_req_o & ~ic_ack_i;
        if (!pc_ce_i) begin
          state_d = IDLE;
          if (!id_stall_i) valid_d = 1'b0;
        end else if (ic_req_o && ic_ack_i) begin
          inst_d  = ic_rdata_i;
          valid_d = 1'b1;
        end else if (ic_req_o) begin
          addr_d       = pc_i;
          valid_d      = 1'b0;
          pend_d       = 1'b0;
          pend_flush_d = 1'b0;
          state_d      = MISS;
        end
      end

      MISS: begin
        ic_req_o    = 1'b1;
        stall_req_o = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;

        // A flush always takes the pending slot; a branch only fills it
        // while no flush is already waiting.
        if (flush_i) begin
          pend_d       = 1'b1;
          pend_flush_d = 1'b1;
          pend_pc_d    = new_pc_i;
        end else if (branch_flag_i && !pend_flush_q) begin
          pend_d    = 1'b1;
          pend_pc_d = branch_target_i;
        end

        if (ic_ack_i) begin
          // Redirects arriving on the ack cycle itself are folded in via
          // pend_d/pend_pc_d so they are replayed rather than lost.
          if (pend_d) begin
            redir_d      = 1'b1;
            rpc_d        = pend_pc_d;
            valid_d      = 1'b0;
            pend_d       = 1'b0;
            pend_flush_d = 1'b0;
            state_d      = pc_ce_i ? FETCH : IDLE;
          end else if (id_stall_i) begin
            hold_d  = ic_rdata_i;
            state_d = HOLD;
          end else begin
            inst_d  = ic_rdata_i;
            valid_d = 1'b1;
            state_d = pc_ce_i ? FETCH : IDLE;
          end
        end
      end

      HOLD: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!id_stall_i) begin
          inst_d  = hold_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase

    // A flush in any state kills the instruction presented to ID.
    if (flush_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      hold_q       <= '0;
      inst_q       <= NOP_INST;
      valid_q      <= 1'b0;
      redir_q      <= 1'b0;
      rpc_q        <= '0;
      pend_q       <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      redir_q      <= redir_d;
      rpc_q        <= rpc_d;
      pend_q       <= pend_d;
      pend_flush_q <= pend_flush_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign inst_o        = inst_q;
  assign inst_valid_o  = valid_q;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = rpc_q;
  assign miss_cnt_o    = cnt_q;

endmodule
